jt1943_snd_post: RTL



---
 rtl/jt1943_snd_pkg.sv | 13 +
 rtl/jt1943_snd_post_if.sv | 27 ++
 rtl/jt1943_snd_dcblk.sv | 43 ++++
 rtl/jt1943_snd_post.sv | 122 ++++++++++++
 4 files changed

// File: rtl/jt1943_snd_pkg.sv
// Shared widths and saturation limits for the 1943 sound post-processing stage.
package jt1943_snd_pkg;

  localparam int unsigned SND_DW         = 16;
  localparam int unsigned DECIM_LOG2_DEF = 5;
  localparam int unsigned GAIN_W         = 8;
  localparam int unsigned GAIN_FRAC      = 4;

  localparam logic [GAIN_W-1:0]        GAIN_UNITY = 8'h10;
  localparam logic signed [SND_DW-1:0] SAT_MAX    = 16'sh7FFF;
  localparam logic signed [SND_DW-1:0] SAT_MIN    = 16'sh8000;

endpackage

// File: rtl/jt1943_snd_post_if.sv
// Sample-in / sample-out bundle between the sound block, the post stage and the platform audio.
interface jt1943_snd_post_if
  import jt1943_snd_pkg::*;
#(
  parameter int unsigned DW = SND_DW,
  parameter int unsigned GW = GAIN_W
);

  logic                 cen1p5;
  logic signed [DW-1:0] snd_in;
  logic [GW-1:0]        gain;
  logic                 mute;
  logic signed [DW-1:0] snd_out;
  logic                 sample;
  logic                 clip;

  modport master (
    output cen1p5, snd_in, gain, mute,
    input  snd_out, sample, clip
  );

  modport slave (
    input  cen1p5, snd_in, gain, mute,
    output snd_out, sample, clip
  );

endinterface

// File: rtl/jt1943_snd_dcblk.sv
// First-order DC-blocking high-pass: y = x - x1 + y1 - (y1 >>> 8), saturated, one clk latency.
module jt1943_snd_dcblk
  import jt1943_snd_pkg::*;
#(
  parameter int unsigned DW = SND_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_v,
  input  logic signed [DW-1:0] x,
  output logic                 out_v,
  output logic signed [DW-1:0] y
);

  localparam int unsigned IW = DW + 2;
  localparam logic signed [IW-1:0] I_MAX = IW'(SAT_MAX);
  localparam logic signed [IW-1:0] I_MIN = IW'(SAT_MIN);

  logic signed [DW-1:0] x1;
  logic signed [IW-1:0] y_c;

  // y doubles as y1: it only changes when a new sample is filtered
  always_comb begin
    y_c = IW'(x) - IW'(x1) + IW'(y) - (IW'(y) >>> 8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1    <= '0;
      y     <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= in_v;
      if (in_v) begin
        x1 <= x;
        if (y_c > I_MAX)      y <= SAT_MAX;
        else if (y_c < I_MIN) y <= SAT_MIN;
        else                  y <= DW'(y_c);
      end
    end
  end

endmodule

// File: rtl/jt1943_snd_post.sv
// 1943 sound post stage: 32:1 boxcar decimation, 4.4 gain with saturation, mute, strobed output.
// Optional DC blocker between average and gain when JT1943_SND_DCBLOCK_EN is defined.
module jt1943_snd_post
  import jt1943_snd_pkg::*;
#(
  parameter int unsigned DW         = SND_DW,
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int unsigned GW         = GAIN_W
) (
  input  logic             clk,
  input  logic             rst,
  jt1943_snd_post_if.slave snd
);

  localparam int unsigned AW = DW + DECIM_LOG2;
  localparam int unsigned PW = DW + GW + 1;
  localparam logic signed [PW-1:0] P_MAX = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] P_MIN = PW'(SAT_MIN);

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic [DECIM_LOG2-1:0]  cnt;
  logic                   v1;
  logic signed [DW-1:0]   avg;
  logic                   v2;
  logic signed [DW-1:0]   g_in;
  logic                   g_v;
  logic signed [PW-1:0]   prod_c;
  logic signed [PW-1:0]   scl_c;
  logic signed [DW-1:0]   sat_val;
  logic                   sat_flag;
  logic                   v3;

  // Stage 0: accumulate one window; the closing sample goes straight into sum
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sum <= '0;
      cnt <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= 1'b0;
      if (snd.cen1p5) begin
        cnt <= cnt + DECIM_LOG2'(1);
        if (cnt == '1) begin
          sum <= acc + AW'(snd.snd_in);
          acc <= '0;
          v1  <= 1'b1;
        end else begin
          acc <= acc + AW'(snd.snd_in);
        end
      end
    end
  end

  // Stage 1: average by arithmetic shift (rounds toward -inf)
  always_ff @(posedge clk) begin
    if (rst) begin
      avg <= '0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) avg <= DW'(sum >>> DECIM_LOG2);
    end
  end

`ifdef JT1943_SND_DCBLOCK_EN
  jt1943_snd_dcblk #(.DW(DW)) u_dcblk (
    .clk   (clk),
    .rst   (rst),
    .in_v  (v2),
    .x     (avg),
    .out_v (g_v),
    .y     (g_in)
  );
`else
  assign g_v  = v2;
  assign g_in = avg;
`endif

  always_comb begin
    prod_c = PW'(g_in) * PW'($signed({1'b0, snd.gain}));
    scl_c  = prod_c >>> GAIN_FRAC;
  end

  // Stage 2: gain and saturate; gain is sampled here
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_val  <= '0;
      sat_flag <= 1'b0;
      v3       <= 1'b0;
    end else begin
      v3 <= g_v;
      if (g_v) begin
        if (scl_c > P_MAX) begin
          sat_val  <= SAT_MAX;
          sat_flag <= 1'b1;
        end else if (scl_c < P_MIN) begin
          sat_val  <= SAT_MIN;
          sat_flag <= 1'b1;
        end else begin
          sat_val  <= DW'(scl_c);
          sat_flag <= 1'b0;
        end
      end
    end
  end

  // Stage 3: output register; mute is sampled here and snd_out holds between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      snd.snd_out <= '0;
      snd.sample  <= 1'b0;
      snd.clip    <= 1'b0;
    end else begin
      snd.sample <= v3;
      snd.clip   <= v3 & sat_flag & ~snd.mute;
      if (v3) snd.snd_out <= snd.mute ? '0 : sat_val;
    end
  end

endmodule
